// File: rtl/execute_stage.sv
// Execute stage of the 16-bit pipeline.
// Computes the ALU result and registers it, together with the pass-through
// controls, into the execute/memory boundary. MUL runs as an iterative
// shift-add sequence and holds the upstream stages with stall until the
// product is ready.
module execute_stage #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wbs_in,
  input  logic             wme_in,
  input  logic             mm_in,
  input  logic [2:0]       ALUop_in,
  input  logic             wm_in,
  input  logic             am_in,
  input  logic             ni_in,
  input  logic [WIDTH-1:0] srcA_in,
  input  logic [WIDTH-1:0] srcB_in,
  output logic             stall,
  output logic             wbs_out,
  output logic             wme_out,
  output logic             mm_out,
  output logic             wm_out,
  output logic             am_out,
  output logic             ni_out,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] store_out,
  output logic             zero_out,
  output logic             neg_out
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    MUL_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   count;

  logic               start_mul;
  logic               take;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   alu_result;
  logic [WIDTH-1:0]   wr_result;

  assign shamt     = srcB_in[SH_W-1:0];
  assign start_mul = (ALUop_in == 3'b111) && !ni_in;

  // Single-cycle ALU; MUL is produced by the sequencer, so it yields 0 here.
  always_comb begin
    // NOTE: default first so every path assigns alu_result and no latch is inferred.
    alu_result = '0;
    case (ALUop_in)
      3'b000:  alu_result = srcA_in + srcB_in;
      3'b001:  alu_result = srcA_in - srcB_in;
      3'b010:  alu_result = srcA_in & srcB_in;
      3'b011:  alu_result = srcA_in | srcB_in;
      3'b100:  alu_result = srcA_in ^ srcB_in;
      3'b101:  alu_result = srcA_in << shamt;
      3'b110:  alu_result = srcA_in >> shamt;
      default: alu_result = '0;
    endcase
  end

  // Hold upstream while a MUL is starting or iterating; flush and reset release it.
  assign stall = !rst && !flush &&
                 (((state == IDLE) && start_mul) || (state == MUL_BUSY));

  // A real instruction is written either straight from IDLE or at MUL completion.
  assign take      = !flush && (((state == IDLE) && !start_mul) || (state == MUL_DONE));
  assign wr_result = (state == MUL_DONE) ? acc : alu_result;

  // Shift-add multiply sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge values.
      case (state)
        IDLE: begin
          if (start_mul) begin
            mcand  <= srcA_in;
            mplier <= srcB_in;
            acc    <= '0;
            count  <= '0;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST_ITER) state <= MUL_DONE;
        end
        MUL_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Execute/memory boundary register: real result when taken, otherwise a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbs_out    <= 1'b0;
      wme_out    <= 1'b0;
      mm_out     <= 1'b0;
      wm_out     <= 1'b0;
      am_out     <= 1'b0;
      ni_out     <= 1'b1;
      result_out <= '0;
      store_out  <= '0;
      zero_out   <= 1'b1;
      neg_out    <= 1'b0;
    end else if (take) begin
      wbs_out    <= wbs_in;
      wme_out    <= wme_in;
      mm_out     <= mm_in;
      wm_out     <= wm_in;
      am_out     <= am_in;
      ni_out     <= ni_in;
      result_out <= wr_result;
      store_out  <= srcB_in;
      zero_out   <= (wr_result == '0);
      neg_out    <= wr_result[WIDTH-1];
    end else begin
      wbs_out <= 1'b0;
      wme_out <= 1'b0;
      mm_out  <= 1'b0;
      wm_out  <= 1'b0;
      am_out  <= 1'b0;
      ni_out  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes the expected content of
// the boundary register for every clock edge, a monitor pops and compares.
module tb_execute_stage;

  localparam int WIDTH      = 16;
  localparam int MUL_CYCLES = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             wbs_in = 1'b0, wme_in = 1'b0, mm_in = 1'b0;
  logic             wm_in = 1'b0, am_in = 1'b0, ni_in = 1'b1;
  logic [2:0]       ALUop_in = 3'b000;
  logic [WIDTH-1:0] srcA_in = '0, srcB_in = '0;
  logic             stall;
  logic             wbs_out, wme_out, mm_out, wm_out, am_out, ni_out;
  logic [WIDTH-1:0] result_out, store_out;
  logic             zero_out, neg_out;

  execute_stage #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .ALUop_in(ALUop_in),
    .wm_in(wm_in), .am_in(am_in), .ni_in(ni_in),
    .srcA_in(srcA_in), .srcB_in(srcB_in), .stall(stall),
    .wbs_out(wbs_out), .wme_out(wme_out), .mm_out(mm_out),
    .wm_out(wm_out), .am_out(am_out), .ni_out(ni_out),
    .result_out(result_out), .store_out(store_out),
    .zero_out(zero_out), .neg_out(neg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             wbs, wme, mm, wm, am, ni;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
  } instr_t;

  typedef struct {
    logic [5:0]       ctrl;   // {wbs, wme, mm, wm, am, ni}
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] store;
    logic [1:0]       flags;  // {zero, neg}
    bit               rchk;   // result/flags are defined for this entry
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 0;
  int   checks = 0;
  int   errors = 0;

  // Architectural view of the boundary register held across bubbles.
  logic [WIDTH-1:0] h_result = '0;
  logic [WIDTH-1:0] h_store  = '0;
  logic [1:0]       h_flags  = 2'b10;
  bit               h_known  = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: plain integer arithmetic, truncated to WIDTH bits.
  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    int unsigned ua = a, ub = b, sh = b % 16, r;
    case (op)
      3'd0: r = ua + ub;
      3'd1: r = ua - ub;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua << sh;
      3'd6: r = ua >> sh;
      default: r = ua * ub;
    endcase
    return r[WIDTH-1:0];
  endfunction

  task automatic model_reset();
    h_result = '0;
    h_store  = '0;
    h_flags  = 2'b10;
    h_known  = 1;
  endtask

  task automatic drive(input instr_t ins);
    wbs_in = ins.wbs; wme_in = ins.wme; mm_in = ins.mm;
    wm_in = ins.wm; am_in = ins.am; ni_in = ins.ni;
    ALUop_in = ins.op; srcA_in = ins.a; srcB_in = ins.b;
  endtask

  // Present one instruction from a negedge until it is consumed (or flushed
  // on cycle flush_at); ends on a negedge.
  task automatic issue(input instr_t ins, input int flush_at);
    bit   is_mul;
    bit   done;
    bit   exp_stall;
    int   n;
    exp_t e;
    logic [WIDTH-1:0] r;
    is_mul = (ins.op == 3'b111) && !ins.ni;
    n = is_mul ? MUL_CYCLES + 2 : 1;
    done = 0;
    for (int c = 0; c < n && !done; c++) begin
      drive(ins);
      flush = (c == flush_at);
      if (flush || (is_mul && c < n - 1)) begin
        e.ctrl = 6'b000001; e.result = h_result; e.store = h_store;
        e.flags = h_flags; e.rchk = h_known;
        exp_stall = !flush;
        done = flush;
      end else begin
        r = ref_alu(ins.op, ins.a, ins.b);
        e.ctrl = {ins.wbs, ins.wme, ins.mm, ins.wm, ins.am, ins.ni};
        e.result = r; e.store = ins.b;
        e.flags = {(r == 0), r[WIDTH-1]};
        e.rchk = !(ins.ni && ins.op == 3'b111);
        h_result = r; h_store = ins.b; h_flags = e.flags; h_known = e.rchk;
        exp_stall = 0;
      end
      exp_q.push_back(e);
      mon_en = 1;
      #1 check("stall", {31'd0, stall}, {31'd0, exp_stall});
      @(negedge clk);
    end
    flush = 0;
  endtask

  function automatic instr_t mk(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic ni);
    instr_t i;
    i.wbs = 1; i.wme = 0; i.mm = 1; i.wm = 1; i.am = 0; i.ni = ni;
    i.op = op; i.a = a; i.b = b;
    return i;
  endfunction

  // Monitor: one boundary-register entry per clock edge while enabled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=edge expected=entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("ctrl", {26'd0, wbs_out, wme_out, mm_out, wm_out, am_out, ni_out},
                {26'd0, e.ctrl});
          check("store", {16'd0, store_out}, {16'd0, e.store});
          if (e.rchk) begin
            check("result", {16'd0, result_out}, {16'd0, e.result});
            check("flags", {30'd0, zero_out, neg_out}, {30'd0, e.flags});
          end
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t ins;
    int     fa;

    // Reset state, asserted asynchronously before any clock edge.
    #1 rst = 1;
    #2;
    check("rst_ni", {31'd0, ni_out}, 32'd1);
    check("rst_ctrl", {27'd0, wbs_out, wme_out, mm_out, wm_out, am_out}, 32'd0);
    check("rst_result", {16'd0, result_out}, 32'd0);
    check("rst_flags", {30'd0, zero_out, neg_out}, 32'd2);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Directed cases.
    issue(mk(3'b000, 16'h7FFF, 16'h0001, 0), -1);
    issue(mk(3'b001, 16'd5, 16'd5, 0), -1);
    issue(mk(3'b101, 16'h8001, 16'h0011, 0), -1);
    issue(mk(3'b110, 16'h8001, 16'h0011, 0), -1);
    issue(mk(3'b111, 16'h0123, 16'h0045, 0), -1);
    issue(mk(3'b111, 16'hFFFF, 16'hFFFF, 0), -1);
    issue(mk(3'b111, 16'h0007, 16'h0009, 0), 8);
    issue(mk(3'b000, 16'd2, 16'd3, 0), -1);
    ins = mk(3'b111, 16'h1234, 16'h0002, 1);
    ins.wme = 0;
    issue(ins, -1);

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 200; k++) begin
      ins.wbs = 1'($urandom); ins.wme = 1'($urandom); ins.mm = 1'($urandom);
      ins.wm = 1'($urandom); ins.am = 1'($urandom);
      ins.ni = ($urandom_range(0, 7) == 0);
      ins.op = 3'($urandom_range(0, 7));
      ins.a = 16'($urandom);
      ins.b = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      fa = -1;
      if (ins.op == 3'b111 && !ins.ni && $urandom_range(0, 3) == 0)
        fa = $urandom_range(0, MUL_CYCLES + 1);
      else if ($urandom_range(0, 15) == 0)
        fa = 0;
      issue(ins, fa);
    end

    // Reset in the middle of a multiply.
    issue(mk(3'b000, 16'h1111, 16'h2222, 0), -1);
    mon_en = 0;
    ins = mk(3'b111, 16'h00FF, 16'h0033, 0);
    drive(ins);
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst_ni", {31'd0, ni_out}, 32'd1);
    check("mid_rst_result", {16'd0, result_out}, 32'd0);
    check("mid_rst_store", {16'd0, store_out}, 32'd0);
    check("mid_rst_flags", {30'd0, zero_out, neg_out}, 32'd2);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    issue(mk(3'b000, 16'd2, 16'd3, 0), -1);
    issue(mk(3'b111, 16'h0010, 16'h0010, 0), -1);
    issue(mk(3'b100, 16'hA5A5, 16'hA5A5, 0), -1);

    mon_en = 0;
    check("drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 16-bit CPU pipeline.
- Consumes the control and operand outputs of the decode/execute pipeline register, computes the ALU result, and registers result plus pass-through controls into the execute/memory boundary.
- Single-cycle ops complete in one clock.
- MUL is an iterative shift-add FSM that asserts stall to freeze the upstream stages until the product is ready.

Parameters:
- WIDTH, 16, operand/result width.
- MUL_CYCLES, 16, shift-add iterations (equals WIDTH).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill current instruction; registers a bubble and aborts MUL.
- wbs_in  in  1  writeback-select control, passed through.
- wme_in  in  1  memory-write-enable control, passed through.
- mm_in  in  1  memory-mux control, passed through.
- ALUop_in  in  3  ALU operation.
- wm_in  in  1  control, passed through.
- am_in  in  1  control, passed through.
- ni_in  in  1  bubble marker: 1 means no instruction in this slot.
- srcA_in  in  WIDTH  operand A.
- srcB_in  in  WIDTH  operand B; also store data.
- stall  out  1  combinational; upstream holds while 1.
- wbs_out, wme_out, mm_out, wm_out, am_out, ni_out  out  1 each  registered controls.
- result_out  out  WIDTH  registered ALU result.
- store_out  out  WIDTH  registered srcB.
- zero_out  out  1  registered (result==0).
- neg_out  out  1  registered result[WIDTH-1].

Behaviour:
- Reset (async, rst=1):
  - All control outputs 0 except ni_out=1 (bubble).
  - result_out, store_out, neg_out = 0; zero_out = 1.
  - FSM in IDLE, stall=0.
  - Takes effect immediately, mid-MUL included; the partial product is discarded.
- ALUop encoding (all modulo 2^WIDTH, unsigned carry discarded):
  - 000 ADD A+B
  - 001 SUB A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL A<<B[3:0]
  - 110 SRL A>>B[3:0], logical
  - 111 MUL, low WIDTH bits of A*B
- FSM states: IDLE, MUL_BUSY, MUL_DONE.
- IDLE:
  - If ALUop_in≠111 or ni_in=1: the output register captures the combinational result and all controls on the next edge (latency 1).
  - If ALUop_in=111 and ni_in=0: stall=1. Latch A into multiplicand, B into multiplier, acc=0, count=0. Go to MUL_BUSY. The output register captures a bubble (ni_out=1, wbs/wme/mm/wm/am_out=0, result_out held).
- MUL_BUSY:
  - stall=1.
  - Each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
  - After count reaches MUL_CYCLES-1 (16th iteration), go to MUL_DONE.
  - Output register captures bubbles throughout.
- MUL_DONE:
  - stall=0.
  - The output register captures acc plus the held input controls.
  - Unconditionally return to IDLE; the held MUL instruction must not restart.
- MUL total: present on inputs 18 cycles (1 IDLE + 16 BUSY + 1 DONE); result visible after the 18th edge.
- Bubbles (ni_in=1): controls are passed through unchanged (ni_out=1); result is computed but ignored downstream; MUL never starts.
- Flush:
  - Priority rst > flush > normal.
  - On flush=1 the next edge registers a bubble and the FSM returns to IDLE.
  - stall is forced 0 in that cycle.
- zero_out and neg_out are derived from the value written to result_out in the same edge. When a bubble is written, they are unchanged.
- Back-to-back MULs: the second MUL enters IDLE detection on the cycle after MUL_DONE, giving 18 cycles each with no overlap.

Test Plan:
- Reset: assert rst mid-cycle -> immediately ni_out=1, result_out=0, zero_out=1, stall=0.
- ADD then SUB: A=0x7FFF, B=0x0001, op=000 -> result_out=0x8000, neg_out=1 after 1 edge. Next, A=5, B=5, op=001 -> result_out=0, zero_out=1.
- Shifts: A=0x8001, B=0x0011, op=101 -> 0x0002 (shift 1). Then op=110 -> 0x4000.
- MUL: A=0x0123, B=0x0045, op=111 -> stall=1 for exactly 17 cycles, ni_out=1 during them, then result_out=0x4E6F. Wrap case: A=0xFFFF, B=0xFFFF -> 0x0001.
- Flush mid-MUL: flush at BUSY cycle 8 -> stall drops that cycle, next edge ni_out=1, FSM IDLE. A following ADD 2+3 -> result_out=5.
- Bubble with op=111, ni_in=1 -> stall stays 0, ni_out=1 one edge later, wme_out=0.
